// File: rtl/writeback_arbiter.sv
// Shares the register-file/predicate write port between unstallable memory load
// returns and ALU results. ALU results wait in a small in-order FIFO.
module writeback_arbiter #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ADDR_W       = 3,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic              alu_use_rw,
   input  logic [ADDR_W-1:0] alu_rw_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_write_ps,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rw_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_hold,
   output logic              wb_valid,
   output logic              wb_use_rw,
   output logic [ADDR_W-1:0] wb_rw_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_write_ps,
   output logic              wb_ps,
   input  logic [ADDR_W-1:0] query_addr,
   output logic              query_hit
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic              use_rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              write_ps;
   } entry_t;

   entry_t            fifo_q [DEPTH];
   entry_t            fifo_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic              mem_hold_q, mem_hold_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_use_rw_q, wb_use_rw_d;
   logic [ADDR_W-1:0] wb_rw_addr_q, wb_rw_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              wb_write_ps_q, wb_write_ps_d;
   logic              wb_ps_q, wb_ps_d;

   logic              fifo_empty;
   logic              alu_live;
   logic              enq;
   logic              deq;
   logic [CNT_W-1:0]  wr_idx;
   entry_t            alu_entry;
   entry_t            head;

   always_comb begin
      alu_ready  = (count_q < CNT_W'(DEPTH));
      fifo_empty = (count_q == '0);
      alu_live   = alu_valid && alu_ready && (alu_use_rw || alu_write_ps);
      alu_entry  = '{use_rw: alu_use_rw, addr: alu_rw_addr, data: alu_data,
                     write_ps: alu_write_ps};
      head       = fifo_q[0];
      deq        = !mem_valid && !fifo_empty;
      // Bypass only when nothing is buffered and memory is idle; otherwise queue.
      enq        = alu_live && (mem_valid || !fifo_empty);
      wr_idx     = deq ? count_q - 1'b1 : count_q;

      wb_valid_d    = 1'b0;
      wb_use_rw_d   = wb_use_rw_q;
      wb_rw_addr_d  = wb_rw_addr_q;
      wb_data_d     = wb_data_q;
      wb_write_ps_d = wb_write_ps_q;
      wb_ps_d       = wb_ps_q;

      if (mem_valid) begin
         wb_valid_d    = 1'b1;
         wb_use_rw_d   = 1'b1;
         wb_rw_addr_d  = mem_rw_addr;
         wb_data_d     = mem_data;
         wb_write_ps_d = 1'b0;
         wb_ps_d       = 1'b0;
      end else if (!fifo_empty) begin
         wb_valid_d    = 1'b1;
         wb_use_rw_d   = head.use_rw;
         wb_rw_addr_d  = head.addr;
         wb_data_d     = head.data;
         wb_write_ps_d = head.write_ps;
         wb_ps_d       = head.write_ps & head.data[0];
      end else if (alu_live) begin
         wb_valid_d    = 1'b1;
         wb_use_rw_d   = alu_use_rw;
         wb_rw_addr_d  = alu_rw_addr;
         wb_data_d     = alu_data;
         wb_write_ps_d = alu_write_ps;
         wb_ps_d       = alu_write_ps & alu_data[0];
      end

      fifo_d = fifo_q;
      if (deq) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo_d[i] = fifo_q[i + 1];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (enq && CNT_W'(i) == wr_idx) fifo_d[i] = alu_entry;
      end

      count_d = count_q;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;

      starve_d = '0;
      if (mem_valid && !fifo_empty) begin
         starve_d = (starve_q == ST_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
      end
      mem_hold_d = (starve_d == ST_W'(STARVE_LIMIT));

      query_hit = (mem_valid && mem_rw_addr == query_addr) ||
                  (wb_valid_q && wb_use_rw_q && wb_rw_addr_q == query_addr);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && fifo_q[i].use_rw && fifo_q[i].addr == query_addr)
            query_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         count_q       <= '0;
         starve_q      <= '0;
         mem_hold_q    <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_use_rw_q   <= 1'b0;
         wb_rw_addr_q  <= '0;
         wb_data_q     <= '0;
         wb_write_ps_q <= 1'b0;
         wb_ps_q       <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
         count_q       <= count_d;
         starve_q      <= starve_d;
         mem_hold_q    <= mem_hold_d;
         wb_valid_q    <= wb_valid_d;
         wb_use_rw_q   <= wb_use_rw_d;
         wb_rw_addr_q  <= wb_rw_addr_d;
         wb_data_q     <= wb_data_d;
         wb_write_ps_q <= wb_write_ps_d;
         wb_ps_q       <= wb_ps_d;
      end
   end

   assign mem_hold    = mem_hold_q;
   assign wb_valid    = wb_valid_q;
   assign wb_use_rw   = wb_use_rw_q;
   assign wb_rw_addr  = wb_rw_addr_q;
   assign wb_data     = wb_data_q;
   assign wb_write_ps = wb_write_ps_q;
   assign wb_ps       = wb_ps_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writebacks are queued as stimulus
// is issued and a negedge monitor pops and compares every wb_valid cycle.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, alu_use_rw, alu_write_ps;
   logic [2:0]  alu_rw_addr;
   logic [15:0] alu_data;
   logic        mem_valid, mem_hold;
   logic [2:0]  mem_rw_addr;
   logic [15:0] mem_data;
   logic        wb_valid, wb_use_rw, wb_write_ps, wb_ps;
   logic [2:0]  wb_rw_addr;
   logic [15:0] wb_data;
   logic [2:0]  query_addr;
   logic        query_hit;

   writeback_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_use_rw(alu_use_rw),
      .alu_rw_addr(alu_rw_addr), .alu_data(alu_data), .alu_write_ps(alu_write_ps),
      .mem_valid(mem_valid), .mem_rw_addr(mem_rw_addr), .mem_data(mem_data),
      .mem_hold(mem_hold),
      .wb_valid(wb_valid), .wb_use_rw(wb_use_rw), .wb_rw_addr(wb_rw_addr),
      .wb_data(wb_data), .wb_write_ps(wb_write_ps), .wb_ps(wb_ps),
      .query_addr(query_addr), .query_hit(query_hit)
   );

   always #5 clk = ~clk;

   typedef logic [21:0] rec_t;  // {use_rw, addr, data, write_ps, ps}
   rec_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic rec_t mk(input logic u, input logic [2:0] a,
                               input logic [15:0] d, input logic wp);
      return {u, a, d, wp, wp & d[0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      rec_t got;
      if (!rst && wb_valid) begin
         got = {wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps};
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL wb_unexpected: got %0h, expected no writeback", got);
         end else begin
            check("wb_txn", got, exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      alu_valid = 0; alu_use_rw = 0; alu_write_ps = 0; alu_rw_addr = 0; alu_data = 0;
      mem_valid = 0; mem_rw_addr = 0; mem_data = 0;
   endtask

   task automatic alu(input logic u, input logic [2:0] a, input logic [15:0] d, input logic wp);
      alu_valid = 1; alu_use_rw = u; alu_rw_addr = a; alu_data = d; alu_write_ps = wp;
   endtask

   task automatic mem(input logic [2:0] a, input logic [15:0] d);
      mem_valid = 1; mem_rw_addr = a; mem_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; idle(); query_addr = 0;
      #2;
      check("reset_wb", {wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps}, 0);
      check("reset_hold", mem_hold, 0);
      check("reset_ready", alu_ready, 1);
      @(negedge clk); rst = 0;
      tick();

      // Single ALU result bypasses with latency 1
      exp_q.push_back(mk(1, 3, 16'h00A5, 1));
      alu(1, 3, 16'h00A5, 1); #1 check("t1_ready", alu_ready, 1);
      tick(); idle(); query_addr = 3;
      #1 check("t1_hit_wb", query_hit, 1);
      tick();
      #1 check("t1_idle_valid", wb_valid, 0);
      check("t1_fields_held", {wb_rw_addr, wb_data}, {3'd3, 16'h00A5});
      check("t1_no_slot", query_hit, 0);

      // Memory and ALU collide
      exp_q.push_back(mk(1, 1, 16'h1234, 0));
      exp_q.push_back(mk(1, 2, 16'h0042, 0));
      mem(1, 16'h1234); alu(1, 2, 16'h0042, 0); query_addr = 1;
      #1 check("t2_hit_mem", query_hit, 1);
      query_addr = 2;
      tick(); idle();
      #1 check("t2_hit_fifo", query_hit, 1);
      tick();
      #1 check("t2_hit_wb", query_hit, 1);
      tick();
      #1 check("t2_hit_clear", query_hit, 0);

      // Fill FIFO under memory traffic, then drain in order
      exp_q.push_back(mk(1, 4, 16'h1000, 0));
      exp_q.push_back(mk(1, 4, 16'h1001, 0));
      exp_q.push_back(mk(1, 4, 16'h1002, 0));
      exp_q.push_back(mk(1, 5, 16'h0501, 1));
      exp_q.push_back(mk(0, 6, 16'h0602, 1));
      exp_q.push_back(mk(1, 7, 16'h0703, 0));
      mem(4, 16'h1000); alu(1, 5, 16'h0501, 1); #1 check("t3_ready0", alu_ready, 1);
      tick();
      mem(4, 16'h1001); alu(0, 6, 16'h0602, 1); #1 check("t3_ready1", alu_ready, 1);
      tick();
      mem(4, 16'h1002); alu(1, 7, 16'h0703, 0); #1 check("t3_full", alu_ready, 0);
      tick();
      mem_valid = 0; #1 check("t3_full_deq", alu_ready, 0);
      check("t3_hold", mem_hold, 0);
      tick();
      #1 check("t3_ready_back", alu_ready, 1);
      tick(); idle();
      tick(); tick();

      // Starvation raises mem_hold, first dequeue clears it
      exp_q.push_back(mk(1, 1, 16'h2000, 0));
      for (int i = 1; i <= 5; i++) exp_q.push_back(mk(1, 1, 16'h2000 + 16'(i), 0));
      exp_q.push_back(mk(1, 2, 16'h0B0B, 0));
      mem(1, 16'h2000); alu(1, 2, 16'h0B0B, 0);
      tick(); alu_valid = 0;
      for (int i = 1; i <= 4; i++) begin
         mem(1, 16'h2000 + 16'(i));
         #1 check("t4_hold_low", mem_hold, 0);
         tick();
      end
      mem(1, 16'h2005); #1 check("t4_hold_set", mem_hold, 1);
      tick();
      mem_valid = 0; #1 check("t4_hold_kept", mem_hold, 1);
      tick();
      #1 check("t4_hold_clear", mem_hold, 0);
      tick(); tick();

      // No-op result consumes nothing and produces no writeback
      alu(0, 5, 16'hFFFF, 0); query_addr = 5;
      #1 check("t5_ready", alu_ready, 1);
      tick(); idle();
      #1 check("t5_ready_after", alu_ready, 1);
      check("t5_no_wb", wb_valid, 0);
      check("t5_no_hit", query_hit, 0);
      tick(); tick();

      // Asynchronous reset with two entries buffered
      exp_q.push_back(mk(1, 1, 16'h3000, 0));
      mem(1, 16'h3000); alu(1, 3, 16'h0303, 0);
      tick();
      mem(1, 16'h3001); alu(1, 4, 16'h0404, 0);
      tick(); idle();
      #1 check("t6_pre_valid", wb_valid, 1);
      check("t6_pre_full", alu_ready, 0);
      #1 rst = 1;
      #1 check("t6_rst_wb", {wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps}, 0);
      check("t6_rst_hold", mem_hold, 0);
      check("t6_rst_ready", alu_ready, 1);
      query_addr = 3;
      #1 check("t6_rst_hit", query_hit, 0);
      @(posedge clk); #3 rst = 0;
      repeat (6) tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
